// File: rtl/line_window_3x3.sv
// Streaming 3x3 neighbourhood generator for raster-order pixels.
// Two line memories hold the previous two image lines; three column shift
// registers per window row build the 3x3 window presented on d00..d22.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   pix_in               input pixel, raster order
//   pix_valid_in         pix_in accepted this cycle
//   sof_in               with pix_valid_in: this pixel is (row 0, col 0)
//   d00_out..d22_out     window, dRC = row R / column C, 0 = oldest
//   win_valid_out        single-cycle strobe, window outputs valid
//   col_out, row_out     position of the d22 pixel of the current window
module line_window_3x3 #(
    parameter int unsigned DATA_IN_WIDTH = 8,
    parameter int unsigned IMG_WIDTH     = 640,
    parameter int unsigned IMG_HEIGHT    = 480
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_IN_WIDTH-1:0]      pix_in,
    input  logic                          pix_valid_in,
    input  logic                          sof_in,
    output logic [DATA_IN_WIDTH-1:0]      d00_out,
    output logic [DATA_IN_WIDTH-1:0]      d01_out,
    output logic [DATA_IN_WIDTH-1:0]      d02_out,
    output logic [DATA_IN_WIDTH-1:0]      d10_out,
    output logic [DATA_IN_WIDTH-1:0]      d11_out,
    output logic [DATA_IN_WIDTH-1:0]      d12_out,
    output logic [DATA_IN_WIDTH-1:0]      d20_out,
    output logic [DATA_IN_WIDTH-1:0]      d21_out,
    output logic [DATA_IN_WIDTH-1:0]      d22_out,
    output logic                          win_valid_out,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_out,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_out
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam int unsigned PIX_W = DATA_IN_WIDTH;

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] pos_col;
    logic [ROW_W-1:0] pos_row;
    logic [COL_W-1:0] nxt_col;
    logic [ROW_W-1:0] nxt_row;
    logic [PIX_W-1:0] above1;
    logic [PIX_W-1:0] above2;
    logic             win_hit;

    // Line memories: lb0 = line above, lb1 = two lines above. Not reset.
    logic [PIX_W-1:0] lb0 [IMG_WIDTH];
    logic [PIX_W-1:0] lb1 [IMG_WIDTH];

    // Position of the pixel being accepted, following position and window test.
    always_comb begin
        pos_col = col_q;
        pos_row = row_q;
        if (sof_in) begin
            pos_col = '0;
            pos_row = '0;
        end
        nxt_col = pos_col + COL_W'(1);
        nxt_row = pos_row;
        if (pos_col == COL_W'(IMG_WIDTH - 1)) begin
            nxt_col = '0;
            if (pos_row == ROW_W'(IMG_HEIGHT - 1)) begin
                nxt_row = '0;
            end else begin
                nxt_row = pos_row + ROW_W'(1);
            end
        end
        // Asynchronous read returns the pre-write contents on this edge.
        above1  = lb0[pos_col];
        above2  = lb1[pos_col];
        win_hit = (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));
    end

    // Line memory update: the column's line-above value ages into lb1.
    always_ff @(posedge clk) begin
        if (pix_valid_in) begin
            lb1[pos_col] <= above1;
            lb0[pos_col] <= pix_in;
        end
    end

    // Position counters, window shift registers and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q         <= '0;
            row_q         <= '0;
            d00_out       <= '0;
            d01_out       <= '0;
            d02_out       <= '0;
            d10_out       <= '0;
            d11_out       <= '0;
            d12_out       <= '0;
            d20_out       <= '0;
            d21_out       <= '0;
            d22_out       <= '0;
            win_valid_out <= 1'b0;
            col_out       <= '0;
            row_out       <= '0;
        end else begin
            win_valid_out <= pix_valid_in && win_hit;
            if (pix_valid_in) begin
                col_q   <= nxt_col;
                row_q   <= nxt_row;
                d00_out <= d01_out;
                d01_out <= d02_out;
                d02_out <= above2;
                d10_out <= d11_out;
                d11_out <= d12_out;
                d12_out <= above1;
                d20_out <= d21_out;
                d21_out <= d22_out;
                d22_out <= pix_in;
                col_out <= pos_col;
                row_out <= pos_row;
            end
        end
    end

endmodule

// File: tb/tb_line_window_3x3.sv
module tb_line_window_3x3;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix_in;
    logic       pix_valid_in;
    logic       sof_in;
    logic [7:0] d00_out, d01_out, d02_out, d10_out, d11_out, d12_out, d20_out, d21_out, d22_out;
    logic       win_valid_out;
    logic [1:0] col_out;
    logic [1:0] row_out;

    always #5 clk = ~clk;

    line_window_3x3 #(
        .DATA_IN_WIDTH(8),
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_in(pix_in),
        .pix_valid_in(pix_valid_in),
        .sof_in(sof_in),
        .d00_out(d00_out),
        .d01_out(d01_out),
        .d02_out(d02_out),
        .d10_out(d10_out),
        .d11_out(d11_out),
        .d12_out(d12_out),
        .d20_out(d20_out),
        .d21_out(d21_out),
        .d22_out(d22_out),
        .win_valid_out(win_valid_out),
        .col_out(col_out),
        .row_out(row_out)
    );

    wire [71:0] dwin = {d00_out, d01_out, d02_out, d10_out, d11_out, d12_out, d20_out, d21_out, d22_out};

    int errors = 0;
    int checks = 0;

    // Reference model: frame image indexed by position plus a linear pixel index.
    int         m_row, m_col;
    logic [7:0] img [H][W];
    logic       exp_valid;
    int         exp_row, exp_col;
    logic [71:0] exp_win;
    logic       win_known;
    int         wins;

    task automatic model_reset();
        m_row     = 0;
        m_col     = 0;
        exp_valid = 1'b0;
        exp_row   = 0;
        exp_col   = 0;
        exp_win   = '0;
        win_known = 1'b1;
    endtask

    // Drive one cycle, then advance the model for what was accepted.
    task automatic step(input logic v, input logic [7:0] p, input logic s);
        int r, c, idx;
        pix_valid_in = v;
        pix_in       = p;
        sof_in       = s;
        @(posedge clk);
        #1;
        pix_valid_in = 1'b0;
        sof_in       = 1'b0;
        if (v) begin
            r = s ? 0 : m_row;
            c = s ? 0 : m_col;
            img[r][c] = p;
            exp_row   = r;
            exp_col   = c;
            exp_valid = (r >= 2) && (c >= 2);
            if (exp_valid)
                exp_win = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                           img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                           img[r][c-2],   img[r][c-1],   img[r][c]};
            win_known = exp_valid;
            idx   = (r * W + c + 1) % (W * H);
            m_row = idx / W;
            m_col = idx % W;
        end else begin
            exp_valid = 1'b0;
        end
        if (win_valid_out === 1'b1) wins++;
    endtask

    function automatic logic [7:0] pv(input int r, input int c, input int base);
        return 8'(base + 16 * r + c);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        pix_valid_in = 1'b0;
        sof_in = 1'b0;
        pix_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({win_valid_out, row_out, col_out, dwin} !== 77'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%0d c=%0d win=%h want all zero",
                     win_valid_out, row_out, col_out, dwin);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_continuous();
        logic [71:0] first_win;
        bit got_first;
        got_first = 0;
        first_win = '0;
        wins = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, pv(i / 4, i % 4, 0), i == 0);
            checks++;
            if ({win_valid_out, row_out, col_out} !== {exp_valid, 2'(exp_row), 2'(exp_col)}) begin
                errors++;
                $display("FAIL cont_status[%0d]: got v=%b r=%0d c=%0d want v=%b r=%0d c=%0d",
                         i, win_valid_out, row_out, col_out, exp_valid, exp_row, exp_col);
            end
            if (win_known) begin
                checks++;
                if (dwin !== exp_win) begin
                    errors++;
                    $display("FAIL cont_window[%0d]: got %h want %h", i, dwin, exp_win);
                end
            end
            if (win_valid_out === 1'b1 && !got_first) begin
                got_first = 1;
                first_win = dwin;
            end
        end
        checks++;
        if (first_win !== 72'h00_01_02_10_11_12_20_21_22) begin
            errors++;
            $display("FAIL cont_first_window: got %h want 000102101112202122", first_win);
        end
        checks++;
        if ({dwin[71:64], dwin[7:0]} !== 16'h1133) begin
            errors++;
            $display("FAIL cont_last_window: got d00=%h d22=%h want d00=11 d22=33", dwin[71:64], dwin[7:0]);
        end
        checks++;
        if (wins != 4) begin
            errors++;
            $display("FAIL cont_count: got %0d want 4", wins);
        end
    endtask

    task automatic test_gaps();
        wins = 0;
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                step(1'b0, 8'($urandom), 1'b0);
                checks++;
                if ({win_valid_out, row_out, col_out} !== {exp_valid, 2'(exp_row), 2'(exp_col)}) begin
                    errors++;
                    $display("FAIL gap_idle_status[%0d]: got v=%b r=%0d c=%0d want v=%b r=%0d c=%0d",
                             i, win_valid_out, row_out, col_out, exp_valid, exp_row, exp_col);
                end
                if (win_known) begin
                    checks++;
                    if (dwin !== exp_win) begin
                        errors++;
                        $display("FAIL gap_hold[%0d]: got %h want %h", i, dwin, exp_win);
                    end
                end
            end
            step(1'b1, pv(i / 4, i % 4, 0), i == 0);
            checks++;
            if ({win_valid_out, row_out, col_out} !== {exp_valid, 2'(exp_row), 2'(exp_col)}) begin
                errors++;
                $display("FAIL gap_status[%0d]: got v=%b r=%0d c=%0d want v=%b r=%0d c=%0d",
                         i, win_valid_out, row_out, col_out, exp_valid, exp_row, exp_col);
            end
            if (win_known) begin
                checks++;
                if (dwin !== exp_win) begin
                    errors++;
                    $display("FAIL gap_window[%0d]: got %h want %h", i, dwin, exp_win);
                end
            end
        end
        checks++;
        if (wins != 4) begin
            errors++;
            $display("FAIL gap_count: got %0d want 4", wins);
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] first_win;
        bit got_first;
        int early;
        got_first = 0;
        first_win = '0;
        early = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 16) wins = 0;
            step(1'b1, pv((i % 16) / 4, i % 4, (i >= 16) ? 8'h80 : 0), i == 0);
            if (i == 23) early = wins;
            checks++;
            if ({win_valid_out, row_out, col_out} !== {exp_valid, 2'(exp_row), 2'(exp_col)}) begin
                errors++;
                $display("FAIL b2b_status[%0d]: got v=%b r=%0d c=%0d want v=%b r=%0d c=%0d",
                         i, win_valid_out, row_out, col_out, exp_valid, exp_row, exp_col);
            end
            if (win_known) begin
                checks++;
                if (dwin !== exp_win) begin
                    errors++;
                    $display("FAIL b2b_window[%0d]: got %h want %h", i, dwin, exp_win);
                end
            end
            if (i >= 16 && win_valid_out === 1'b1 && !got_first) begin
                got_first = 1;
                first_win = dwin;
            end
        end
        checks++;
        if (first_win !== 72'h80_81_82_90_91_92_A0_A1_A2) begin
            errors++;
            $display("FAIL b2b_first_window: got %h want 808182909192a0a1a2", first_win);
        end
        checks++;
        if (early != 0 || wins != 4) begin
            errors++;
            $display("FAIL b2b_count: got early=%0d total=%0d want early=0 total=4", early, wins);
        end
    endtask

    task automatic test_sof_mid();
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), i == 0);
        wins = 0;
        step(1'b1, 8'($urandom), 1'b1);
        checks++;
        if ({win_valid_out, row_out, col_out} !== 5'b0_00_00) begin
            errors++;
            $display("FAIL sof_mid_restart: got v=%b r=%0d c=%0d want v=0 r=0 c=0",
                     win_valid_out, row_out, col_out);
        end
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 8'($urandom), 1'b0);
            checks++;
            if ({win_valid_out, row_out, col_out} !== {exp_valid, 2'(exp_row), 2'(exp_col)}) begin
                errors++;
                $display("FAIL sof_mid_status[%0d]: got v=%b r=%0d c=%0d want v=%b r=%0d c=%0d",
                         i, win_valid_out, row_out, col_out, exp_valid, exp_row, exp_col);
            end
            if (win_known) begin
                checks++;
                if (dwin !== exp_win) begin
                    errors++;
                    $display("FAIL sof_mid_window[%0d]: got %h want %h", i, dwin, exp_win);
                end
            end
            if (i == 9) begin
                checks++;
                if (wins != 0) begin
                    errors++;
                    $display("FAIL sof_mid_early: got %0d windows want 0", wins);
                end
            end
        end
        checks++;
        if ({win_valid_out, row_out, col_out} !== 5'b1_10_10) begin
            errors++;
            $display("FAIL sof_mid_first: got v=%b r=%0d c=%0d want v=1 r=2 c=2",
                     win_valid_out, row_out, col_out);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) step(1'b1, pv(i / 4, i % 4, 8'h40), i == 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({win_valid_out, row_out, col_out, dwin} !== 77'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b r=%0d c=%0d win=%h want all zero",
                     win_valid_out, row_out, col_out, dwin);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wins = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, pv(i / 4, i % 4, 0), 1'b0);
            checks++;
            if ({win_valid_out, row_out, col_out} !== {exp_valid, 2'(exp_row), 2'(exp_col)}) begin
                errors++;
                $display("FAIL rst_frame_status[%0d]: got v=%b r=%0d c=%0d want v=%b r=%0d c=%0d",
                         i, win_valid_out, row_out, col_out, exp_valid, exp_row, exp_col);
            end
            if (win_known) begin
                checks++;
                if (dwin !== exp_win) begin
                    errors++;
                    $display("FAIL rst_frame_window[%0d]: got %h want %h", i, dwin, exp_win);
                end
            end
            if (i == 10) begin
                checks++;
                if (dwin !== 72'h00_01_02_10_11_12_20_21_22) begin
                    errors++;
                    $display("FAIL rst_frame_first: got %h want 000102101112202122", dwin);
                end
            end
        end
        checks++;
        if (wins != 4) begin
            errors++;
            $display("FAIL rst_frame_count: got %0d want 4", wins);
        end
    endtask

    task automatic test_sof_wrap();
        for (int i = 0; i < 16; i++) step(1'b1, pv(i / 4, i % 4, 0), i == 0);
        checks++;
        if ({win_valid_out, row_out, col_out, dwin[7:0]} !== {5'b1_11_11, 8'h33}) begin
            errors++;
            $display("FAIL wrap_last: got v=%b r=%0d c=%0d d22=%h want v=1 r=3 c=3 d22=33",
                     win_valid_out, row_out, col_out, dwin[7:0]);
        end
        step(1'b1, 8'h5A, 1'b1);
        checks++;
        if ({win_valid_out, row_out, col_out, dwin[7:0]} !== {5'b0_00_00, 8'h5A}) begin
            errors++;
            $display("FAIL wrap_sof: got v=%b r=%0d c=%0d d22=%h want v=0 r=0 c=0 d22=5a",
                     win_valid_out, row_out, col_out, dwin[7:0]);
        end
        step(1'b1, 8'h5B, 1'b0);
        checks++;
        if ({win_valid_out, row_out, col_out} !== {exp_valid, 2'(exp_row), 2'(exp_col)} ||
            {win_valid_out, row_out, col_out} !== 5'b0_00_01) begin
            errors++;
            $display("FAIL wrap_next: got v=%b r=%0d c=%0d want v=0 r=0 c=1",
                     win_valid_out, row_out, col_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_sof_mid();
        test_async_reset();
        test_sof_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
